// File: rtl/jtag_dmi_dtm.sv
// JTAG Debug Transport Module (RISC-V debug 0.13 DTM semantics).
// Holds the IDCODE, DTMCS, DMI and BYPASS data registers behind the TAP. A completed DMI
// scan becomes one valid/ready request toward the Debug Module. Only one transaction
// may be outstanding at a time.
// Optional feature: define JTAG_DTM_HARDRESET_EN to make DTMCS.dmihardreset (bit 17)
// abort the in-flight transaction and clear the sticky error.
module jtag_dmi_dtm #(
  parameter int unsigned IR_W      = 5,
  parameter int unsigned ABITS     = 7,
  parameter logic [31:0] IDCODE    = 32'h1000_0001,
  parameter logic [2:0]  IDLE_HINT = 3'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IR_W-1:0]  ir,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic             tdi,
  output logic             tdo,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_resp_valid,
  output logic             dmi_resp_ready,
  input  logic [31:0]      dmi_resp_data,
  input  logic [1:0]       dmi_resp_op
);

  localparam int unsigned     DMI_W     = ABITS + 34;
  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(32'h01);
  localparam logic [IR_W-1:0] IR_DTMCS  = IR_W'(32'h10);
  localparam logic [IR_W-1:0] IR_DMI    = IR_W'(32'h11);
  localparam logic [5:0]      ABITS_F   = 6'(ABITS);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e             state_q;
  logic [31:0]        idcode_q;
  logic [31:0]        dtmcs_q;
  logic [DMI_W-1:0]   dmi_q;
  logic               bypass_q;
  logic [1:0]         sticky_q;
  logic [ABITS-1:0]   last_addr_q;
  logic [31:0]        last_data_q;
  logic [31:0]        req_data_q;
  logic [1:0]         req_op_q;

  logic sel_idcode, sel_dtmcs, sel_dmi;

  // Instruction decode; every unlisted instruction selects BYPASS.
  always_comb begin
    sel_idcode = (ir == IR_IDCODE);
    sel_dtmcs  = (ir == IR_DTMCS);
    sel_dmi    = (ir == IR_DMI);
  end

  // TDO is the LSB of the selected register only, so there is no combinational tdi path.
  always_comb begin
    tdo = bypass_q;
    if (sel_idcode)     tdo = idcode_q[0];
    else if (sel_dtmcs) tdo = dtmcs_q[0];
    else if (sel_dmi)   tdo = dmi_q[0];
  end

  assign dmi_req_addr = last_addr_q;
  assign dmi_req_data = req_data_q;
  assign dmi_req_op   = req_op_q;

  // Data registers, sticky error and the DMI handshake FSM share one state block because
  // scans and the handshake both write the sticky error and the FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      idcode_q       <= '0;
      dtmcs_q        <= '0;
      dmi_q          <= '0;
      bypass_q       <= 1'b0;
      sticky_q       <= 2'd0;
      last_addr_q    <= '0;
      last_data_q    <= '0;
      req_data_q     <= '0;
      req_op_q       <= 2'd0;
      dmi_req_valid  <= 1'b0;
      dmi_resp_ready <= 1'b0;
    end else begin
      if (capture_dr) begin
        if (sel_idcode) begin
          idcode_q <= IDCODE;
        end else if (sel_dtmcs) begin
          dtmcs_q <= {14'b0, 2'b0, 1'b0, IDLE_HINT, sticky_q, ABITS_F, 4'd1};
        end else if (sel_dmi) begin
          if (state_q != StIdle) begin
            // Scanning while busy reports and latches the busy error.
            dmi_q    <= {last_addr_q, last_data_q, 2'd3};
            sticky_q <= 2'd3;
          end else begin
            dmi_q <= {last_addr_q, last_data_q, sticky_q};
          end
        end else begin
          bypass_q <= 1'b0;
        end
      end else if (shift_dr) begin
        if (sel_idcode)     idcode_q <= {tdi, idcode_q[31:1]};
        else if (sel_dtmcs) dtmcs_q  <= {tdi, dtmcs_q[31:1]};
        else if (sel_dmi)   dmi_q    <= {tdi, dmi_q[DMI_W-1:1]};
        else                bypass_q <= tdi;
      end else if (update_dr) begin
        if (sel_dtmcs && dtmcs_q[16]) begin
          sticky_q <= 2'd0;
        end else if (sel_dmi) begin
          if (state_q != StIdle) begin
            sticky_q <= 2'd3;
          end else if (sticky_q == 2'd0 && (dmi_q[1:0] == 2'd1 || dmi_q[1:0] == 2'd2)) begin
            last_addr_q   <= dmi_q[DMI_W-1:34];
            req_data_q    <= dmi_q[33:2];
            req_op_q      <= dmi_q[1:0];
            state_q       <= StReq;
            dmi_req_valid <= 1'b1;
          end
        end
      end

      case (state_q)
        StIdle: ;
        StReq: begin
          if (dmi_req_valid && dmi_req_ready) begin
            state_q        <= StResp;
            dmi_req_valid  <= 1'b0;
            dmi_resp_ready <= 1'b1;
          end
        end
        StResp: begin
          if (dmi_resp_valid && dmi_resp_ready) begin
            state_q        <= StIdle;
            dmi_resp_ready <= 1'b0;
            last_data_q    <= dmi_resp_data;
            if (dmi_resp_op != 2'd0) sticky_q <= 2'd2;
          end
        end
        default: state_q <= StIdle;
      endcase

`ifdef JTAG_DTM_HARDRESET_EN
      // Hard reset overrides any handshake progress made in the same cycle.
      if (update_dr && !capture_dr && !shift_dr && sel_dtmcs && dtmcs_q[17]) begin
        sticky_q       <= 2'd0;
        state_q        <= StIdle;
        dmi_req_valid  <= 1'b0;
        dmi_resp_ready <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_jtag_dmi_dtm.sv
// Bench for jtag_dmi_dtm: a table of DR scans plus hand-written sequences for busy,
// error, reset and hard-reset behaviour. DMI requests are checked by a scoreboard.
module tb_jtag_dmi_dtm;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ir;
  logic        capture_dr, shift_dr, update_dr, tdi;
  logic        tdo;
  logic        dmi_req_valid, dmi_req_ready;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0]  dmi_req_op;
  logic        dmi_resp_valid, dmi_resp_ready;
  logic [31:0] dmi_resp_data;
  logic [1:0]  dmi_resp_op;

  always #5 clk = ~clk;

  jtag_dmi_dtm dut (
    .clk            (clk),
    .rst            (rst),
    .ir             (ir),
    .capture_dr     (capture_dr),
    .shift_dr       (shift_dr),
    .update_dr      (update_dr),
    .tdi            (tdi),
    .tdo            (tdo),
    .dmi_req_valid  (dmi_req_valid),
    .dmi_req_ready  (dmi_req_ready),
    .dmi_req_addr   (dmi_req_addr),
    .dmi_req_data   (dmi_req_data),
    .dmi_req_op     (dmi_req_op),
    .dmi_resp_valid (dmi_resp_valid),
    .dmi_resp_ready (dmi_resp_ready),
    .dmi_resp_data  (dmi_resp_data),
    .dmi_resp_op    (dmi_resp_op)
  );

  int ntests = 0;
  int nfail  = 0;
  int beats  = 0;
  logic [63:0] exp_q[$];

  // Debug Module model: responds whenever enabled.
  logic        dm_auto;
  logic [31:0] dm_data;
  logic [1:0]  dm_op;
  assign dmi_resp_valid = dm_auto;
  assign dmi_resp_data  = dm_data;
  assign dmi_resp_op    = dm_op;

  typedef struct {
    logic [4:0]  ir;
    int          w;
    logic [63:0] din;
    logic [63:0] exp;
    logic [31:0] dm;
    bit          push;
    string       name;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [63:0] dmi(input logic [6:0] a, input logic [31:0] d,
                                      input logic [1:0] o);
    return {23'b0, a, d, o};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Scoreboard: each accepted request beat is matched against the next expected request.
  always begin
    @(negedge clk);
    #1;
    if (dmi_req_valid && dmi_req_ready) begin
      beats++;
      if (exp_q.size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL req_unexpected: got addr %h op %0d, required no request",
                 dmi_req_addr, dmi_req_op);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("req_beat", {23'b0, dmi_req_addr, dmi_req_data, dmi_req_op}, e);
      end
    end
  end

  // Full capture/shift/update sequence; dout collects tdo LSB-first.
  task automatic scan(input logic [4:0] ir_v, input int w, input logic [63:0] din,
                      output logic [63:0] dout);
    dout = '0;
    @(negedge clk);
    ir = ir_v;
    capture_dr = 1'b1;
    @(negedge clk);
    capture_dr = 1'b0;
    shift_dr = 1'b1;
    for (int i = 0; i < w; i++) begin
      tdi = din[i];
      dout[i] = tdo;
      @(negedge clk);
    end
    shift_dr = 1'b0;
    tdi = 1'b0;
    update_dr = 1'b1;
    @(negedge clk);
    update_dr = 1'b0;
  endtask

  task automatic wait_resp_ready(input string name);
    for (int i = 0; i < 20; i++) begin
      if (dmi_resp_ready) break;
      @(negedge clk);
    end
    check(name, dmi_resp_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d, e;
    int b0;

    vecs[0]  = '{5'h01, 32, 64'h0,  64'h1000_0001,    32'h0, 1'b0, "idcode"};
    vecs[1]  = '{5'h01, 40, 64'hC3, 64'hC3_1000_0001, 32'h0, 1'b0, "idcode_pass"};
    vecs[2]  = '{5'h10, 32, 64'h0,  64'h1071,         32'h0, 1'b0, "dtmcs"};
    vecs[3]  = '{5'h1F, 8,  64'hA5, 64'h4A,           32'h0, 1'b0, "bypass_1f"};
    vecs[4]  = '{5'h00, 8,  64'h3C, 64'h78,           32'h0, 1'b0, "bypass_00"};
    vecs[5]  = '{5'h11, 41, dmi(7'h10, 32'h1, 2'd2), 64'h0, 32'h1234_5678, 1'b1, "dmi_write"};
    vecs[6]  = '{5'h11, 41, 64'h0, dmi(7'h10, 32'h1234_5678, 2'd0), 32'h1234_5678, 1'b0,
                 "dmi_nop1"};
    vecs[7]  = '{5'h11, 41, dmi(7'h05, 32'h0, 2'd1), dmi(7'h10, 32'h1234_5678, 2'd0),
                 32'hCAFE_F00D, 1'b1, "dmi_read"};
    vecs[8]  = '{5'h11, 41, 64'h0, dmi(7'h05, 32'hCAFE_F00D, 2'd0), 32'hCAFE_F00D, 1'b0,
                 "dmi_nop2"};
    vecs[9]  = '{5'h11, 41, dmi(7'h7F, 32'hFFFF_FFFF, 2'd3), dmi(7'h05, 32'hCAFE_F00D, 2'd0),
                 32'hCAFE_F00D, 1'b0, "dmi_op3"};
    vecs[10] = '{5'h11, 41, 64'h0, dmi(7'h05, 32'hCAFE_F00D, 2'd0), 32'hCAFE_F00D, 1'b0,
                 "dmi_op3_noaction"};

    rst = 1'b1; ir = 5'h00; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    tdi = 1'b0; dmi_req_ready = 1'b1; dm_auto = 1'b1; dm_data = '0; dm_op = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_tdo", tdo, 0);
    check("reset_req_valid", dmi_req_valid, 0);
    check("reset_resp_ready", dmi_resp_ready, 0);

    for (int i = 0; i < 11; i++) begin
      dm_data = vecs[i].dm;
      if (vecs[i].push) exp_q.push_back(vecs[i].din);
      scan(vecs[i].ir, vecs[i].w, vecs[i].din, d);
      check(vecs[i].name, d, vecs[i].exp);
      repeat (6) @(negedge clk);
    end

    // Busy: DM withholds the response, a second DMI scan reports op 3 and issues nothing.
    dm_auto = 1'b0;
    dm_data = 32'h0BAD_0001;
    exp_q.push_back(dmi(7'h22, 32'h0, 2'd1));
    scan(5'h11, 41, dmi(7'h22, 32'h0, 2'd1), d);
    check("busy_launch_cap", d, dmi(7'h05, 32'hCAFE_F00D, 2'd0));
    wait_resp_ready("busy_resp_ready");
    b0 = beats;
    scan(5'h11, 41, dmi(7'h23, 32'h55, 2'd2), d);
    check("busy_cap_op3", d, dmi(7'h22, 32'hCAFE_F00D, 2'd3));
    repeat (6) @(negedge clk);
    check("busy_no_req", 64'(beats), 64'(b0));
    scan(5'h10, 32, 64'h0001_0000, d);
    check("dtmcs_busy_stat", d, 64'h1C71);
    scan(5'h10, 32, 64'h0, d);
    check("dtmcs_cleared", d, 64'h1071);
    check("inflight_kept", dmi_resp_ready, 1);
    dm_auto = 1'b1;
    repeat (4) @(negedge clk);
    check("busy_done", dmi_resp_ready, 0);
    dm_auto = 1'b0;
    scan(5'h11, 41, 64'h0, d);
    check("busy_after", d, dmi(7'h22, 32'h0BAD_0001, 2'd0));

    // Error response: sticky 2 blocks further requests until dmireset.
    dm_auto = 1'b1;
    dm_op = 2'd2;
    dm_data = 32'hEEEE_0002;
    exp_q.push_back(dmi(7'h33, 32'h0, 2'd1));
    scan(5'h11, 41, dmi(7'h33, 32'h0, 2'd1), d);
    check("err_launch_cap", d, dmi(7'h22, 32'h0BAD_0001, 2'd0));
    repeat (6) @(negedge clk);
    scan(5'h11, 41, 64'h0, d);
    check("err_cap", d, dmi(7'h33, 32'hEEEE_0002, 2'd2));
    b0 = beats;
    scan(5'h11, 41, dmi(7'h34, 32'h77, 2'd2), d);
    check("err_cap_again", d, dmi(7'h33, 32'hEEEE_0002, 2'd2));
    repeat (6) @(negedge clk);
    check("err_no_req", 64'(beats), 64'(b0));
    scan(5'h10, 32, 64'h0001_0000, d);
    check("dtmcs_err_stat", d, 64'h1871);
    dm_op = 2'd0;
    dm_data = 32'h0000_600D;
    exp_q.push_back(dmi(7'h44, 32'h0, 2'd1));
    scan(5'h11, 41, dmi(7'h44, 32'h0, 2'd1), d);
    check("err_cleared_cap", d, dmi(7'h33, 32'hEEEE_0002, 2'd0));
    repeat (6) @(negedge clk);

    // Reset mid-transaction drops it silently.
    dm_auto = 1'b0;
    exp_q.push_back(dmi(7'h55, 32'h0, 2'd1));
    scan(5'h11, 41, dmi(7'h55, 32'h0, 2'd1), d);
    check("rst_launch_cap", d, dmi(7'h44, 32'h0000_600D, 2'd0));
    wait_resp_ready("rst_resp_ready");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_resp_ready", dmi_resp_ready, 0);
    check("rst_req_valid", dmi_req_valid, 0);
    check("rst_tdo", tdo, 0);
    scan(5'h11, 41, 64'h0, d);
    check("rst_cap", d, 64'h0);

    // Hard reset while waiting for a response.
    dm_data = 32'h1111_2222;
    exp_q.push_back(dmi(7'h66, 32'h0, 2'd1));
    scan(5'h11, 41, dmi(7'h66, 32'h0, 2'd1), d);
    check("hr_launch_cap", d, 64'h0);
    wait_resp_ready("hr_resp_ready_before");
    scan(5'h10, 32, 64'h0002_0000, d);
    check("hr_dtmcs_cap", d, 64'h1071);
`ifdef JTAG_DTM_HARDRESET_EN
    check("hr_resp_ready", dmi_resp_ready, 0);
    dm_auto = 1'b1;
    repeat (6) @(negedge clk);
    check("hr_late_resp", dmi_resp_ready, 0);
    dm_auto = 1'b0;
    scan(5'h11, 41, 64'h0, d);
    check("hr_cap", d, dmi(7'h66, 32'h0, 2'd0));
`else
    check("hr_ignored", dmi_resp_ready, 1);
    dm_auto = 1'b1;
    repeat (4) @(negedge clk);
    dm_auto = 1'b0;
    scan(5'h11, 41, 64'h0, d);
    check("hr_ignored_cap", d, dmi(7'h66, 32'h1111_2222, 2'd0));
`endif

    repeat (4) @(negedge clk);
    e = 64'(exp_q.size());
    check("sb_empty", e, 64'h0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
